// File: rtl/gemm_csr_queue.sv
// GEMM tile-configuration register window: stages descriptor fields from the host
// and commits them into a first-word-fall-through command FIFO for the tile engine.
module gemm_csr_queue #(
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        system_bus_en,
    input  logic        system_bus_rdwr,
    input  logic [31:0] system_bus_addr,
    input  logic [31:0] system_bus_wr_data,
    output logic [31:0] system_bus_rd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_a_addr,
    output logic [31:0] cmd_b_addr,
    output logic [31:0] cmd_c_addr,
    output logic [31:0] cmd_a_stride,
    output logic [31:0] cmd_b_stride,
    output logic        cmd_first,
    output logic        cmd_last,
    output logic [4:0]  cmd_msize,
    output logic [4:0]  cmd_ksize,
    output logic [4:0]  cmd_nsize,
    input  logic        engine_busy,
    output logic        irq_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = 5 * 32 + 2 + 15;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [2:0] OFF_A    = 3'd0;
    localparam logic [2:0] OFF_B    = 3'd1;
    localparam logic [2:0] OFF_C    = 3'd2;
    localparam logic [2:0] OFF_SA   = 3'd3;
    localparam logic [2:0] OFF_SB   = 3'd4;
    localparam logic [2:0] OFF_CTRL = 3'd5;
    localparam logic [2:0] OFF_DIM  = 3'd6;
    localparam logic [2:0] OFF_STAT = 3'd7;

    logic [31:0] st_a, st_b, st_c, st_sa, st_sb;
    logic        st_first, st_last;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic ovf, dimerr, seen_commit, done_q;
    logic hit, wr_en, rd_en, commit, dim_ok, push_req, push_ok, pop;
    logic full, empty, done;
    logic [2:0]  off;
    logic [3:0]  count_field;
    logic [31:0] rd_mux;
    logic [DW-1:0] push_desc;
    logic addr_unused;

    assign addr_unused = ^system_bus_addr[1:0];

    assign hit    = (system_bus_addr[31:5] == BASE_ADDR[31:5]);
    assign off    = system_bus_addr[4:2];
    assign wr_en  = system_bus_en && system_bus_rdwr && hit;
    assign rd_en  = system_bus_en && !system_bus_rdwr;

    assign commit   = wr_en && (off == OFF_DIM);
    assign dim_ok   = (|system_bus_wr_data[4:0]) && (|system_bus_wr_data[9:5])
                      && (|system_bus_wr_data[14:10]);
    assign push_req = commit && dim_ok;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign cmd_valid = !empty;
    assign pop       = cmd_valid && cmd_ready;
    // When full, a same-cycle pop frees the slot the write pointer already points at.
    assign push_ok   = push_req && (!full || pop);

    assign done        = empty && !engine_busy && seen_commit;
    assign count_field = 4'(count);

    assign push_desc = {st_a, st_b, st_c, st_sa, st_sb, st_first, st_last,
                        system_bus_wr_data[14:10], system_bus_wr_data[9:5],
                        system_bus_wr_data[4:0]};

    assign {cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_a_stride, cmd_b_stride,
            cmd_first, cmd_last, cmd_nsize, cmd_ksize, cmd_msize} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_a     <= '0;
            st_b     <= '0;
            st_c     <= '0;
            st_sa    <= '0;
            st_sb    <= '0;
            st_first <= 1'b0;
            st_last  <= 1'b0;
        end else if (wr_en) begin
            case (off)
                OFF_A:    st_a  <= system_bus_wr_data;
                OFF_B:    st_b  <= system_bus_wr_data;
                OFF_C:    st_c  <= system_bus_wr_data;
                OFF_SA:   st_sa <= system_bus_wr_data;
                OFF_SB:   st_sb <= system_bus_wr_data;
                OFF_CTRL: begin
                    st_first <= system_bus_wr_data[1];
                    st_last  <= system_bus_wr_data[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_desc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A new error in the same cycle as its clear is kept: set wins over W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf         <= 1'b0;
            dimerr      <= 1'b0;
            seen_commit <= 1'b0;
        end else begin
            if (push_req && !push_ok)
                ovf <= 1'b1;
            else if (wr_en && off == OFF_STAT && system_bus_wr_data[3])
                ovf <= 1'b0;
            if (commit && !dim_ok)
                dimerr <= 1'b1;
            else if (wr_en && off == OFF_STAT && system_bus_wr_data[4])
                dimerr <= 1'b0;
            if (push_ok) seen_commit <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            irq_done <= 1'b0;
        end else begin
            done_q   <= done;
            irq_done <= done && !done_q;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (hit) begin
            case (off)
                OFF_A:    rd_mux = {31'b0, full};
                OFF_B:    rd_mux = st_b;
                OFF_C:    rd_mux = st_c;
                OFF_SA:   rd_mux = st_sa;
                OFF_SB:   rd_mux = st_sb;
                OFF_CTRL: rd_mux = {30'b0, st_first, st_last};
                OFF_DIM:  rd_mux = {31'b0, done};
                OFF_STAT: rd_mux = {20'b0, count_field, 3'b0, dimerr, ovf, done, empty, full};
                default:  rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     system_bus_rd_data <= '0;
        else if (rd_en) system_bus_rd_data <= rd_mux;
    end

endmodule

// File: tb/tb_gemm_csr_queue.sv
// Randomized bench for gemm_csr_queue against a queue-based model of the register map.
module tb_gemm_csr_queue;

    localparam logic [31:0] BASE  = 32'h9000_0000;
    localparam int          DEPTH = 4;

    logic        clk, rst_n;
    logic        system_bus_en, system_bus_rdwr;
    logic [31:0] system_bus_addr, system_bus_wr_data, system_bus_rd_data;
    logic        cmd_valid, cmd_ready, engine_busy, irq_done;
    logic [31:0] cmd_a_addr, cmd_b_addr, cmd_c_addr, cmd_a_stride, cmd_b_stride;
    logic        cmd_first, cmd_last;
    logic [4:0]  cmd_msize, cmd_ksize, cmd_nsize;

    gemm_csr_queue #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .system_bus_en(system_bus_en), .system_bus_rdwr(system_bus_rdwr),
        .system_bus_addr(system_bus_addr), .system_bus_wr_data(system_bus_wr_data),
        .system_bus_rd_data(system_bus_rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a_addr(cmd_a_addr), .cmd_b_addr(cmd_b_addr), .cmd_c_addr(cmd_c_addr),
        .cmd_a_stride(cmd_a_stride), .cmd_b_stride(cmd_b_stride),
        .cmd_first(cmd_first), .cmd_last(cmd_last),
        .cmd_msize(cmd_msize), .cmd_ksize(cmd_ksize), .cmd_nsize(cmd_nsize),
        .engine_busy(engine_busy), .irq_done(irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, c, sa, sb;
        logic        first, last;
        logic [4:0]  m, k, n;
    } desc_t;

    desc_t       q[$];
    desc_t       st;
    bit          m_ovf, m_dimerr, m_seen;
    logic [31:0] exp_rd;
    int          n_tests, n_fail, irq_cnt;

    always @(negedge clk) if (rst_n && irq_done) irq_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input logic busy);
        logic full, empty, done;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        done  = empty && !busy && m_seen;
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0:    return {31'b0, full};
            3'd1:    return st.b;
            3'd2:    return st.c;
            3'd3:    return st.sa;
            3'd4:    return st.sb;
            3'd5:    return {30'b0, st.first, st.last};
            3'd6:    return {31'b0, done};
            default: return {20'b0, 4'(q.size()), 3'b0, m_dimerr, m_ovf, done, empty, full};
        endcase
    endfunction

    task automatic check_outputs();
        chk("cmd_valid", {31'b0, cmd_valid}, {31'b0, q.size() != 0});
        chk("rd_data", system_bus_rd_data, exp_rd);
        if (q.size() != 0) begin
            chk("head_a", cmd_a_addr, q[0].a);
            chk("head_b", cmd_b_addr, q[0].b);
            chk("head_c", cmd_c_addr, q[0].c);
            chk("head_sa", cmd_a_stride, q[0].sa);
            chk("head_sb", cmd_b_stride, q[0].sb);
            chk("head_flags", {30'b0, cmd_first, cmd_last}, {30'b0, q[0].first, q[0].last});
            chk("head_dims", {17'b0, cmd_nsize, cmd_ksize, cmd_msize},
                {17'b0, q[0].n, q[0].k, q[0].m});
        end
    endtask

    task automatic cycle(input bit en_i, input bit wr_i, input logic [31:0] addr_i,
                         input logic [31:0] data_i, input bit rdy_i, input bit busy_i);
        bit    pop, hit;
        int    size_before;
        desc_t d;
        system_bus_en      = en_i;
        system_bus_rdwr    = wr_i;
        system_bus_addr    = addr_i;
        system_bus_wr_data = data_i;
        cmd_ready          = rdy_i;
        engine_busy        = busy_i;
        if (en_i && !wr_i) exp_rd = model_read(addr_i, busy_i);
        size_before = q.size();
        pop = rdy_i && (size_before != 0);
        hit = (addr_i[31:5] == BASE[31:5]);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (en_i && wr_i && hit) begin
            case (addr_i[4:2])
                3'd0: st.a  = data_i;
                3'd1: st.b  = data_i;
                3'd2: st.c  = data_i;
                3'd3: st.sa = data_i;
                3'd4: st.sb = data_i;
                3'd5: begin st.first = data_i[1]; st.last = data_i[0]; end
                3'd6: begin
                    d   = st;
                    d.m = data_i[4:0];
                    d.k = data_i[9:5];
                    d.n = data_i[14:10];
                    if (d.m == 0 || d.k == 0 || d.n == 0) m_dimerr = 1;
                    else if (size_before < DEPTH || pop) begin
                        q.push_back(d);
                        m_seen = 1;
                    end else m_ovf = 1;
                end
                default: begin
                    if (data_i[3]) m_ovf = 0;
                    if (data_i[4]) m_dimerr = 0;
                end
            endcase
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic wr(input int off, input logic [31:0] data, input bit rdy = 0, input bit busy = 0);
        cycle(1, 1, BASE + 32'(off), data, rdy, busy);
    endtask

    task automatic rd(input int off, input bit rdy = 0, input bit busy = 0);
        cycle(1, 0, BASE + 32'(off), 32'h0, rdy, busy);
    endtask

    task automatic idle(input bit rdy, input bit busy);
        cycle(0, 0, 32'h0, 32'h0, rdy, busy);
    endtask

    function automatic logic [31:0] rand_dims();
        return {17'b0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                5'($urandom_range(1, 31))};
    endfunction

    task automatic stage_random();
        wr(0, $urandom);
        wr(4, $urandom);
        wr(20, $urandom_range(0, 3));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("cmd_valid_async_reset", {31'b0, cmd_valid}, 32'h0);
        q.delete();
        st       = '{default: '0};
        m_ovf    = 0;
        m_dimerr = 0;
        m_seen   = 0;
        exp_rd   = '0;
        system_bus_en = 1'b0;
        cmd_ready     = 1'b0;
        engine_busy   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        n_tests = 0; n_fail = 0; irq_cnt = 0;
        st = '{default: '0};
        m_ovf = 0; m_dimerr = 0; m_seen = 0; exp_rd = '0;
        rst_n = 1'b0;
        system_bus_en = 0; system_bus_rdwr = 0; system_bus_addr = '0; system_bus_wr_data = '0;
        cmd_ready = 0; engine_busy = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        chk("irq_reset", {31'b0, irq_done}, 32'h0);

        // Reset reads, then the reference descriptor.
        rd(24);
        rd(0);
        wr(0, 0); wr(4, 400); wr(8, 800); wr(12, 20); wr(16, 20); wr(20, 3);
        wr(24, 16 | (16 << 5) | (16 << 10));
        chk("first_msize", {27'b0, cmd_msize}, 32'd16);
        rd(4); rd(20); rd(28);
        idle(1, 0);
        rd(28);

        // Fill with ready low, then overflow and W1C.
        for (int i = 0; i < DEPTH; i++) begin
            stage_random();
            wr(24, rand_dims());
        end
        rd(0);
        wr(24, rand_dims());
        rd(28);
        chk("ovf_set", {31'b0, system_bus_rd_data[3]}, 32'h1);
        wr(28, 32'h8);
        rd(28);

        // Full FIFO plus a same-cycle pop accepts the push.
        stage_random();
        wr(24, rand_dims(), 1);
        rd(28);
        chk("full_push_pop_count", {28'b0, system_bus_rd_data[11:8]}, 32'd4);
        repeat (DEPTH) idle(1, 0);

        // Zero ksize is rejected.
        wr(24, 3 | (0 << 5) | (2 << 10));
        rd(28);
        wr(28, 32'h10);
        rd(28);

        // Random traffic, including out-of-window accesses and misaligned low bits.
        for (int i = 0; i < 400; i++) begin
            int          op;
            logic [31:0] addr, data;
            bit          rdy, busy;
            op   = $urandom_range(0, 9);
            rdy  = ($urandom_range(0, 2) == 0);
            busy = $urandom_range(0, 1);
            addr = BASE | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 7)) << 2);
            data = $urandom;
            case (op)
                0, 1, 2: cycle(1, 1, (BASE | 32'd24 | 32'($urandom_range(0, 3))),
                               ($urandom_range(0, 7) == 0) ? (data & 32'h7fff) : rand_dims(),
                               rdy, busy);
                3, 4:    cycle(1, 1, addr, data, rdy, busy);
                5, 6, 7: cycle(1, 0, addr, 32'h0, rdy, busy);
                8:       cycle(1, $urandom_range(0, 1), addr ^ (32'h1 << $urandom_range(5, 31)),
                               data, rdy, busy);
                default: idle(rdy, busy);
            endcase
        end

        // Reset with descriptors queued.
        while (q.size() != 0) idle(1, 0);
        wr(24, rand_dims());
        wr(24, rand_dims());
        do_reset();
        rd(28);
        chk("count_after_reset", {28'b0, system_bus_rd_data[11:8]}, 32'h0);

        // Completion with the engine busy for 10 cycles per descriptor.
        irq_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            stage_random();
            wr(24, rand_dims());
        end
        for (int i = 0; i < 3; i++) begin
            idle(1, 1);
            repeat (8) idle(0, 1);
            rd(24, 0, 1);
            idle(0, 0);
        end
        rd(24);
        chk("done_after_busy", system_bus_rd_data, 32'h1);
        repeat (4) idle(0, 0);
        chk("irq_once", irq_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
